// File: rtl/program_counter_sync_if.sv
// program_counter_sync_if: control/fetch handshake bundle for the PC.
// master = control+fetch side, slave = program counter.
interface program_counter_sync_if #(
  parameter int WIDTH = 8
);
  logic             req_in;
  logic [1:0]       op;
  logic             rel;
  logic [WIDTH-1:0] target;
  logic             ack;
  logic [WIDTH-1:0] pc_out;
  logic             valid_out;
  logic             ack_in;
  logic             ovf;

  modport master (
    output req_in, op, rel, target, ack_in,
    input  ack, pc_out, valid_out, ovf
  );

  modport slave (
    input  req_in, op, rel, target, ack_in,
    output ack, pc_out, valid_out, ovf
  );
endinterface

// File: rtl/program_counter_sync.sv
// program_counter_sync: clocked PC with hold/+1/+STRIDE/branch steps.
// Optional PC_OVF_TRAP_EN: wrapped updates load TRAP_VEC instead.
module program_counter_sync #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int unsigned      STRIDE   = 2,
  parameter logic [WIDTH-1:0] TRAP_VEC = '1
) (
  input logic                   clk,
  input logic                   rst_n,
  program_counter_sync_if.slave bus
);

  localparam int EW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    PRESENT,
    RELEASE
  } state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic             rel;
    logic [WIDTH-1:0] target;
  } req_t;

  state_t           state_q;
  state_t           state_d;
  req_t             req_q;
  logic [WIDTH-1:0] pc_q;
  logic             valid_q;
  logic             ack_q;
  logic             ovf_q;

  logic             latch_en;
  logic             upd_en;
  logic             clr_valid;
  logic             clr_ack;

  logic [EW-1:0]    pc_ext;
  logic [EW-1:0]    tgt_ext;
  logic [EW-1:0]    sum;
  logic             wrap;
  logic [WIDTH-1:0] pc_next;

  // next-state and per-state strobes
  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    upd_en    = 1'b0;
    clr_valid = 1'b0;
    clr_ack   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_in && !bus.ack_in) begin
          latch_en = 1'b1;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        upd_en  = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (bus.ack_in) begin
          clr_valid = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.req_in && !bus.ack_in) begin
          clr_ack = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // two guard bits catch both carry-out and relative borrow
  always_comb begin
    pc_ext  = {2'b00, pc_q};
    tgt_ext = {{2{req_q.target[WIDTH-1]}}, req_q.target};
    sum     = pc_ext;
    unique case (1'b1)
      (req_q.op == 2'b00): sum = pc_ext;
      (req_q.op == 2'b01): sum = pc_ext + EW'(1);
      (req_q.op == 2'b10): sum = pc_ext + EW'(STRIDE);
      (req_q.op == 2'b11): begin
        if (req_q.rel) begin
          sum = pc_ext + tgt_ext;
        end else begin
          sum = {2'b00, req_q.target};
        end
      end
      default: sum = pc_ext;
    endcase
    wrap = |sum[EW-1:WIDTH];
`ifdef PC_OVF_TRAP_EN
    pc_next = wrap ? TRAP_VEC : sum[WIDTH-1:0];
`else
    pc_next = sum[WIDTH-1:0];
`endif
  end

`ifndef PC_OVF_TRAP_EN
  // trap vector has no consumer in the wrapping build
  logic unused_trap;
  assign unused_trap = ^TRAP_VEC;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // capture the request operands at the IDLE sampling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (latch_en) begin
      req_q.op     <= bus.op;
      req_q.rel    <= bus.rel;
      req_q.target <= bus.target;
    end
  end

  // registered PC, handshake flags and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RST_VAL;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (upd_en) begin
        pc_q    <= pc_next;
        valid_q <= 1'b1;
        ack_q   <= 1'b1;
        ovf_q   <= ovf_q | wrap;
      end
      if (clr_valid) begin
        valid_q <= 1'b0;
      end
      if (clr_ack) begin
        ack_q <= 1'b0;
      end
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.valid_out = valid_q;
  assign bus.ack       = ack_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_program_counter_sync.sv
// tb_program_counter_sync: table vectors, corner sequences and
// randomized transactions against an integer reference model.
module tb_program_counter_sync;

  localparam int W = 8;
  localparam int STRIDE = 2;
  localparam logic [W-1:0] TRAP = 8'hFF;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  program_counter_sync_if #(.WIDTH(W)) bus();

  program_counter_sync #(
    .WIDTH(W),
    .RST_VAL(8'h00),
    .STRIDE(STRIDE),
    .TRAP_VEC(TRAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: got no summary want finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0] op;
    logic       rel;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic       ovf;
  } vec_t;

  vec_t       tbl[11];
  logic [7:0] pc_m;
  logic       ov_m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // reference: integer arithmetic, range check decides overflow
  task automatic model(input logic [1:0] o, input logic r,
                       input logic [7:0] t);
    int v;
    case (o)
      2'b00:   v = int'(pc_m);
      2'b01:   v = int'(pc_m) + 1;
      2'b10:   v = int'(pc_m) + STRIDE;
      default: v = r ? int'(pc_m) + int'($signed(t)) : int'(t);
    endcase
    if (v < 0 || v > 255) begin
      ov_m = 1'b1;
`ifdef PC_OVF_TRAP_EN
      pc_m = TRAP;
`else
      pc_m = 8'(v & 255);
`endif
    end else begin
      pc_m = 8'(v);
    end
  endtask

  task automatic reset_dut();
    bus.req_in = 1'b0;
    bus.ack_in = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // full four-phase transaction with checks at every phase
  task automatic txn(input logic [1:0] o, input logic r,
                     input logic [7:0] t, input logic [7:0] e_pc,
                     input logic e_ovf, input int hold);
    bus.op     = o;
    bus.rel    = r;
    bus.target = t;
    bus.req_in = 1'b1;
    step();
    chk("upd_valid_low", bus.valid_out, 0);
    bus.op     = ~o;
    bus.rel    = ~r;
    bus.target = ~t;
    step();
    chk("valid_rise", bus.valid_out, 1);
    chk("ack_rise", bus.ack, 1);
    chk("pc", bus.pc_out, e_pc);
    chk("ovf", bus.ovf, e_ovf);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("valid_hold", bus.valid_out, 1);
    end
    bus.ack_in = 1'b1;
    step();
    chk("valid_clr", bus.valid_out, 0);
    chk("ack_kept", bus.ack, 1);
    bus.ack_in = 1'b0;
    step();
    chk("ack_wait_req", bus.ack, 1);
    bus.req_in = 1'b0;
    step();
    chk("ack_fall", bus.ack, 0);
    chk("pc_stable", bus.pc_out, e_pc);
  endtask

  initial begin
    logic [1:0] o;
    logic       r;
    logic [7:0] t;
    total = 0;
    bad   = 0;

    tbl[0]  = '{2'b11, 1'b0, 8'h10, 8'h10, 1'b0};
    tbl[1]  = '{2'b01, 1'b0, 8'h00, 8'h11, 1'b0};
    tbl[2]  = '{2'b10, 1'b0, 8'h00, 8'h13, 1'b0};
    tbl[3]  = '{2'b11, 1'b0, 8'h40, 8'h40, 1'b0};
    tbl[4]  = '{2'b11, 1'b0, 8'h80, 8'h80, 1'b0};
    tbl[5]  = '{2'b11, 1'b1, 8'hF0, 8'h70, 1'b0};
    tbl[6]  = '{2'b11, 1'b0, 8'h22, 8'h22, 1'b0};
    tbl[7]  = '{2'b00, 1'b0, 8'h00, 8'h22, 1'b0};
    tbl[8]  = '{2'b11, 1'b0, 8'hFF, 8'hFF, 1'b0};
`ifdef PC_OVF_TRAP_EN
    tbl[9]  = '{2'b01, 1'b0, 8'h00, 8'hFF, 1'b1};
    tbl[10] = '{2'b00, 1'b0, 8'h00, 8'hFF, 1'b1};
`else
    tbl[9]  = '{2'b01, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[10] = '{2'b00, 1'b0, 8'h00, 8'h00, 1'b1};
`endif

    bus.req_in = 1'b0;
    bus.ack_in = 1'b0;
    bus.op     = 2'b00;
    bus.rel    = 1'b0;
    bus.target = 8'h00;
    rst_n      = 1'b0;
    #3;
    chk("rst_pc", bus.pc_out, 8'h00);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_ovf", bus.ovf, 0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      txn(tbl[i].op, tbl[i].rel, tbl[i].tgt,
          tbl[i].pc, tbl[i].ovf, i % 3);
    end

    pc_m = tbl[10].pc;
    ov_m = 1'b1;

    // stall: fetch still holding ack_in when control requests
    bus.ack_in = 1'b1;
    step();
    bus.op     = 2'b01;
    bus.rel    = 1'b0;
    bus.req_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.pc_out, pc_m);
      chk("stall_valid", bus.valid_out, 0);
      chk("stall_ack", bus.ack, 0);
    end
    bus.ack_in = 1'b0;
    model(2'b01, 1'b0, 8'h00);
    step();
    step();
    chk("stall_done_pc", bus.pc_out, pc_m);
    chk("stall_done_valid", bus.valid_out, 1);
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
    bus.req_in = 1'b0;
    step();
    chk("stall_ack_fall", bus.ack, 0);

    // req_in withdrawn right after sampling
    bus.op     = 2'b10;
    bus.req_in = 1'b1;
    model(2'b10, 1'b0, 8'h00);
    step();
    bus.req_in = 1'b0;
    step();
    chk("drop_valid", bus.valid_out, 1);
    chk("drop_ack", bus.ack, 1);
    chk("drop_pc", bus.pc_out, pc_m);
    bus.ack_in = 1'b1;
    step();
    chk("drop_valid_clr", bus.valid_out, 0);
    bus.ack_in = 1'b0;
    step();
    chk("drop_ack_fall", bus.ack, 0);

    // asynchronous reset while presenting
    bus.op     = 2'b01;
    bus.req_in = 1'b1;
    step();
    step();
    chk("pre_rst_valid", bus.valid_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", bus.pc_out, 8'h00);
    chk("async_rst_valid", bus.valid_out, 0);
    chk("async_rst_ack", bus.ack, 0);
    chk("async_rst_ovf", bus.ovf, 0);
    bus.req_in = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", bus.ack, 0);

    pc_m = 8'h00;
    ov_m = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0 && i % 20 == 0) begin
        reset_dut();
        pc_m = 8'h00;
        ov_m = 1'b0;
      end
      o = 2'($urandom_range(0, 3));
      r = 1'($urandom);
      t = 8'($urandom);
      if (o == 2'b11 && r && ($urandom_range(0, 1) == 1)) begin
        t = 8'($urandom_range(0, 7)) | 8'h00;
      end
      model(o, r, t);
      txn(o, r, t, pc_m, ov_m, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
